// File: rtl/cpu_pkg.sv
// Shared MIPS32 pipeline constants and the IF/ID bundle type.
package cpu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0040_0000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

  // IF/ID payload, also consumed by the decode stage.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with load / hold / bubble controls; bubble keeps pc_plus4.
import cpu_pkg::*;

module if_id_reg #(
  parameter logic [XLEN-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic   clk,
  input  logic   i_reset,
  input  logic   i_load,
  input  logic   i_bubble,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_q.inst     <= NOP_INST;
      r_q.pc_plus4 <= '0;
      r_q.valid    <= 1'b0;
    end else if (i_bubble) begin
      r_q.inst  <= NOP_INST;
      r_q.valid <= 1'b0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS32 instruction-fetch stage: PC register, next-PC select and IF/ID register.
// Optional perf counters enabled with `define IF_PERF_CNT_EN.
import cpu_pkg::*;

module if_fetch_stage #(
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [XLEN-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            flush,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_inst,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_fetch_cnt,
  output logic [XLEN-1:0] perf_squash_cnt
`endif
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_load;
  logic            w_bubble;
  logic            w_unused_tgt_lo;
  if_id_t          w_if_id_d;
  if_id_t          w_if_id_q;

  assign w_pc_plus4      = r_pc + XLEN'(INST_BYTES);
  assign w_unused_tgt_lo = ^redirect_target[1:0];

  // Redirect squashes the wrong-path fetch even under stall; stall+flush still bubbles.
  assign w_bubble = redirect_valid | flush;
  assign w_load   = ~redirect_valid & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_target[XLEN-1:2], 2'b00};
    end else if (!stall) begin
      r_pc <= w_pc_plus4;
    end
  end

  assign w_if_id_d.inst     = imem_inst;
  assign w_if_id_d.pc_plus4 = w_pc_plus4;
  assign w_if_id_d.valid    = 1'b1;

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk      (clk),
    .i_reset  (reset),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_d      (w_if_id_d),
    .o_q      (w_if_id_q)
  );

  assign imem_addr   = r_pc;
  assign id_inst     = w_if_id_q.inst;
  assign id_pc_plus4 = w_if_id_q.pc_plus4;
  assign id_valid    = w_if_id_q.valid;

`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] r_fetch_cnt;
  logic [XLEN-1:0] r_squash_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt  <= '0;
      r_squash_cnt <= '0;
    end else begin
      if (w_load)   r_fetch_cnt  <= r_fetch_cnt + XLEN'(1);
      if (w_bubble) r_squash_cnt <= r_squash_cnt + XLEN'(1);
    end
  end

  assign perf_fetch_cnt  = r_fetch_cnt;
  assign perf_squash_cnt = r_squash_cnt;
`endif

endmodule
